// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of an asynchronous FIFO: binary/Gray write
// pointer, registered full/almost-full/level against a synchronized Gray read pointer.
`ifndef FIFO_ADDR_WIDTH
`define FIFO_ADDR_WIDTH 4
`endif

module fifo_wptr_full #(
  parameter int AF_MARGIN = 2
) (
  input  logic                        clk,
  input  logic                        restn,
  input  logic                        wr_en,
  input  logic [`FIFO_ADDR_WIDTH-1:0] rptr_sync,
  input  logic                        ovf_clr,
  output logic [`FIFO_ADDR_WIDTH-2:0] waddr,
  output logic                        ram_we,
  output logic [`FIFO_ADDR_WIDTH-1:0] wptr_gray,
  output logic                        full,
  output logic                        almost_full,
  output logic [`FIFO_ADDR_WIDTH-1:0] level,
  output logic                        overflow
);

  localparam int N     = `FIFO_ADDR_WIDTH;
  localparam int A     = N - 1;
  localparam int DEPTH = 2 ** A;
  localparam logic [N-1:0] AF_THRESH = N'(DEPTH - AF_MARGIN);

  logic [N-1:0] wbin_q, wbin_d;
  logic [N-1:0] wgray_q, wgray_d;
  logic         full_q, full_d;
  logic         af_q, af_d;
  logic [N-1:0] level_q, level_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] rbin;
  logic         push;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  assign rbin[N-1] = rptr_sync[N-1];
  for (genvar gi = N - 2; gi >= 0; gi--) begin : g_rbin
    assign rbin[gi] = rbin[gi+1] ^ rptr_sync[gi];
  end

  assign push = wr_en & ~full_q & restn;

  always_comb begin
    wbin_d  = wbin_q + N'(push);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    level_d = wbin_d - rbin;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rptr_sync[N-1:N-2], rptr_sync[N-3:0]});
    af_d    = (level_d >= AF_THRESH);
    ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!restn) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr       = wbin_q[A-1:0];
  assign ram_we      = push;
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (N=4, DEPTH=8, AF_MARGIN=2): occupancy-count
// model checked every cycle plus literal expectations for fill, overflow, drain, wrap.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       restn;
  logic       wr_en;
  logic [3:0] rptr_sync;
  logic       ovf_clr;
  logic [2:0] waddr;
  logic       ram_we;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  int rcount  = 0;
  bit cmp_en  = 1'b0;

  int   m_w     = 0;
  bit   m_full  = 1'b0;
  bit   m_af    = 1'b0;
  int   m_level = 0;
  bit   m_ovf   = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] rc4;
  assign rc4       = rcount[3:0];
  assign rptr_sync = gray4(rc4);

  fifo_wptr_full #(.AF_MARGIN(2)) dut (
    .clk(clk), .restn(restn), .wr_en(wr_en), .rptr_sync(rptr_sync),
    .ovf_clr(ovf_clr), .waddr(waddr), .ram_we(ram_we), .wptr_gray(wptr_gray),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count total writes and reads as plain integers; occupancy is their difference.
  always @(posedge clk) begin : model
    int p;
    int occ;
    if (!restn) begin
      m_w <= 0; m_full <= 1'b0; m_af <= 1'b0; m_level <= 0; m_ovf <= 1'b0;
    end else begin
      p   = (wr_en && !m_full) ? 1 : 0;
      occ = m_w + p - rcount;
      m_w     <= m_w + p;
      m_level <= occ % 16;
      m_full  <= (occ == 8);
      m_af    <= (occ >= 6);
      m_ovf   <= (wr_en && m_full) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] mw4;
      mw4 = m_w[3:0];
      chk("m_waddr", 32'(waddr), 32'(m_w % 8));
      chk("m_ram_we", 32'(ram_we), 32'(wr_en && !m_full && restn));
      chk("m_wptr_gray", 32'(wptr_gray), 32'(gray4(mw4)));
      chk("m_full", 32'(full), 32'(m_full));
      chk("m_almost_full", 32'(almost_full), 32'(m_af));
      chk("m_level", 32'(level), 32'(m_level));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      $display("cyc t=%0t restn=%0b wr_en=%0b clr=%0b rptr=%h | waddr=%0d we=%0b gray=%h full=%0b af=%0b lvl=%0d ovf=%0b",
               $time, restn, wr_en, ovf_clr, rptr_sync, waddr, ram_we, wptr_gray,
               full, almost_full, level, overflow);
    end
  end

  task automatic tick();
    @(posedge clk);
    #6;
  endtask

  logic [3:0] gray_tbl [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
  logic [23:0] wr_pat = 24'b1101_1110_0111_1011_0011_1101;
  logic [23:0] rd_pat = 24'b0110_1011_1100_0111_1010_0110;

  initial begin
    restn = 1'b0; wr_en = 1'b1; ovf_clr = 1'b0; rcount = 0;

    // Reset held for two clocks with writes requested.
    #1 chk("rst_ram_we0", 32'(ram_we), 0);
    tick();
    cmp_en = 1'b1;
    chk("rst_ram_we1", 32'(ram_we), 0);
    tick();
    chk("rst_outs", {waddr, wptr_gray, full, almost_full, level, overflow}, 0);

    // Fill from empty.
    restn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fill_waddr", 32'(waddr), 32'(i));
      tick();
      chk("fill_gray", 32'(wptr_gray), 32'(gray_tbl[i]));
      if (i == 4) chk("fill_af_5", 32'(almost_full), 0);
      if (i == 5) chk("fill_af_6", 32'(almost_full), 1);
      if (i == 6) chk("fill_full_7", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 8);

    // Overflow: keep writing while full.
    #1 chk("ovf_ram_we", 32'(ram_we), 0);
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_waddr", 32'(waddr), 0);
    chk("ovf_gray", 32'(wptr_gray), 32'hC);
    tick();
    chk("ovf_held", 32'(overflow), 1);
    wr_en = 1'b0; ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 0);

    // Set and clear in the same cycle: set wins.
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("collision", 32'(overflow), 1);
    wr_en = 1'b0;
    tick();
    chk("collision_clr", 32'(overflow), 0);
    ovf_clr = 1'b0;

    // Drain: read side reports binary 3.
    rcount = 3;
    tick();
    chk("drain_full", 32'(full), 0);
    chk("drain_level", 32'(level), 5);
    chk("drain_af", 32'(almost_full), 0);

    // Wrap: reader caught up at 8, push 8 more so wbin returns to 0.
    rcount = 8; wr_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_gray", 32'(wptr_gray), 0);
    chk("wrap_waddr", 32'(waddr), 0);
    chk("wrap_full", 32'(full), 1);
    chk("wrap_level", 32'(level), 8);

    // Mixed directed traffic, reader never overtakes the writer.
    for (int i = 0; i < 24; i++) begin
      wr_en   = wr_pat[i];
      ovf_clr = (i % 7 == 6);
      if (rd_pat[i] && rcount < m_w) rcount = rcount + 1;
      tick();
    end
    ovf_clr = 1'b0;

    // Reset in the middle of a burst discards the write; first push after release hits 0.
    wr_en = 1'b1; restn = 1'b0; rcount = 0;
    #1 chk("midrst_ram_we", 32'(ram_we), 0);
    tick();
    restn = 1'b1;
    #1 chk("post_rst_waddr", 32'(waddr), 0);
    chk("post_rst_we", 32'(ram_we), 1);
    tick();
    chk("post_rst_gray", 32'(wptr_gray), 1);
    chk("post_rst_level", 32'(level), 1);
    wr_en = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Notation: N = `FIFO_ADDR_WIDTH (N >= 3); A = N-1; DEPTH = 2^A; gray(b) = b ^ (b >> 1); all pointer arithmetic is modulo 2^N.

Interface
REQ-001 SHALL have parameter: AF_MARGIN, default 2, almost_full asserts when level >= DEPTH - AF_MARGIN.
REQ-002 SHALL have port: clk  input  1  single write-domain clock; all state on rising edge.
REQ-003 SHALL have port: restn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: wr_en  input  1  write request from producer.
REQ-005 SHALL have port: rptr_sync  input  N  Gray read pointer, already two-flop synchronized into clk domain.
REQ-006 SHALL have port: ovf_clr  input  1  clears sticky overflow.
REQ-007 SHALL have port: waddr  output  A  RAM write address.
REQ-008 SHALL have port: ram_we  output  1  RAM write strobe.
REQ-009 SHALL have port: wptr_gray  output  N  registered Gray write pointer, sent to read-domain synchronizer.
REQ-010 SHALL have port: full  output  1  registered full flag.
REQ-011 SHALL have port: almost_full  output  1  registered almost-full flag.
REQ-012 SHALL have port: level  output  N  registered fill estimate, 0..DEPTH.
REQ-013 SHALL have port: overflow  output  1  sticky write-while-full error.

Function
REQ-014 SHALL define push = wr_en & ~full & restn; ram_we SHALL equal push combinationally.
REQ-015 SHALL hold an N-bit binary pointer wbin; wbin_next = wbin + push.
REQ-016 SHALL drive waddr = wbin[A-1:0] from the register, not from wbin_next.
REQ-017 SHALL register wptr_gray <= gray(wbin_next) on the same edge as wbin, so wptr_gray is a direct flop output (glitch-free for the CDC path).
REQ-018 SHALL register full <= (gray(wbin_next) == {~rptr_sync[N-1:N-2], rptr_sync[N-3:0]}).
REQ-019 SHALL convert rptr_sync to binary rbin (prefix XOR from MSB) and register level <= wbin_next - rbin (N bits).
REQ-020 SHALL register almost_full <= (wbin_next - rbin >= DEPTH - AF_MARGIN).
REQ-021 Full is pessimistic: rptr_sync lags the true read pointer by at least 2 clocks; full SHALL deassert exactly one clock after rptr_sync advances past the full condition.
REQ-022 SHALL leave wbin, waddr, and wptr_gray unchanged and hold ram_we = 0 when wr_en = 1 and full = 1.
REQ-023 SHALL set overflow on the edge after any cycle with wr_en = 1 and full = 1; ovf_clr SHALL clear it; simultaneous set and clear SHALL leave overflow = 1 (set wins).
REQ-024 SHALL wrap wbin from 2^N-1 to 0 with no special handling; flags SHALL remain correct across the wrap.
REQ-025 SHALL contain no FSM beyond the pointer, flag, and sticky registers; latency from wr_en to wptr_gray update SHALL be 1 clock.

Reset
REQ-026 SHALL, on any rising edge with restn = 0, force wbin = 0, wptr_gray = 0, full = 0, almost_full = 0, level = 0, overflow = 0, regardless of wr_en, ovf_clr, and rptr_sync.
REQ-027 SHALL gate ram_we to 0 whenever restn = 0; an assertion of reset mid-burst SHALL discard the in-flight write.
REQ-028 SHALL, with waddr = 0 after reset, make the first push following reset release write address 0.

Verification (N = 4, DEPTH = 8, AF_MARGIN = 2)
REQ-029 Reset: restn = 0 for 2 clocks with wr_en = 1 -> ram_we = 0 throughout; all outputs 0 after the edge.
REQ-030 Fill: rptr_sync = 0, wr_en = 1 for 8 clocks -> waddr 0..7; wptr_gray 1,3,2,6,7,5,4,C; almost_full = 1 after 6th push; full = 1 and level = 8 after 8th push.
REQ-031 Overflow: continue wr_en = 1 while full -> ram_we = 0, waddr stays 0, wptr_gray stays C, overflow = 1 next clock and held; ovf_clr with wr_en = 0 -> overflow = 0.
REQ-032 Drain: from full, rptr_sync = 4'h2 (bin 3) -> next clock full = 0, level = 5, almost_full = 0.
REQ-033 Wrap: rptr_sync = 4'hC (bin 8), wbin = 8, push 8 -> wbin wraps to 0, wptr_gray = 0, full = 1, level = 8.
REQ-034 Collision: full, wr_en = 1 and ovf_clr = 1 same cycle -> overflow remains 1.
